// File: rtl/if_fetch_unit_if.sv
// Bundle between the fetch unit, its synchronous instruction memory and the downstream IF register.
// The master side is the fetch unit. The slave side is the memory and pipeline environment.
interface if_fetch_unit_if #(
  parameter int ADDR_W = 9
);
  logic              stall;
  logic              branch_taken;
  logic [31:0]       branch_target;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic [31:0]       instr;
  logic              instr_valid;
  logic [31:0]       instr_pc;

  modport master (
    input  stall, branch_taken, branch_target, imem_rdata,
    output imem_en, imem_addr, instr, instr_valid, instr_pc
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_rdata,
    input  imem_en, imem_addr, instr, instr_valid, instr_pc
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: PC sequencing, 1-cycle synchronous IMEM read, one-entry skid for stalls,
// and branch redirect that squashes both the in-flight read and the skid.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 9
) (
  input logic             clk,
  input logic             rst,
  if_fetch_unit_if.master bus
);
  logic [31:0] pc_f_reg, pc_f_next;
  logic        inf_v_reg, inf_v_next;
  logic [31:0] inf_pc_reg, inf_pc_next;
  logic        sk_v_reg, sk_v_next;
  logic [31:0] sk_data_reg, sk_data_next;
  logic [31:0] sk_pc_reg, sk_pc_next;
  logic        issue;
  logic [31:0] fetch_addr;

  // A redirect always issues. Otherwise a full skid blocks new reads until it drains.
  always_comb begin
    issue      = bus.branch_taken | (!bus.stall & !sk_v_reg);
    fetch_addr = bus.branch_taken ? (bus.branch_target & ~32'h3) : pc_f_reg;
  end

  assign bus.imem_en   = issue & !rst;
  assign bus.imem_addr = fetch_addr[ADDR_W+1:2];

  always_comb begin
    bus.instr_valid = (sk_v_reg | inf_v_reg) & !bus.branch_taken;
    bus.instr_pc    = sk_v_reg ? sk_pc_reg : inf_pc_reg;
    bus.instr       = 32'h0;
    if (bus.instr_valid)
      bus.instr = sk_v_reg ? sk_data_reg : bus.imem_rdata;
  end

  always_comb begin
    pc_f_next    = pc_f_reg;
    inf_v_next   = issue;
    inf_pc_next  = inf_pc_reg;
    sk_v_next    = sk_v_reg;
    sk_data_next = sk_data_reg;
    sk_pc_next   = sk_pc_reg;
    if (issue) begin
      pc_f_next   = fetch_addr + 32'd4;
      inf_pc_next = fetch_addr;
    end
    // The priority order is branch squash, then skid drain, then skid capture of a read the IF register refused.
    if (bus.branch_taken) begin
      sk_v_next = 1'b0;
    end else if (!bus.stall && sk_v_reg) begin
      sk_v_next = 1'b0;
    end else if (bus.stall && inf_v_reg && !sk_v_reg) begin
      sk_v_next    = 1'b1;
      sk_data_next = bus.imem_rdata;
      sk_pc_next   = inf_pc_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f_reg    <= RESET_PC;
      inf_v_reg   <= 1'b0;
      inf_pc_reg  <= 32'h0;
      sk_v_reg    <= 1'b0;
      sk_data_reg <= 32'h0;
      sk_pc_reg   <= 32'h0;
    end else begin
      pc_f_reg    <= pc_f_next;
      inf_v_reg   <= inf_v_next;
      inf_pc_reg  <= inf_pc_next;
      sk_v_reg    <= sk_v_next;
      sk_data_reg <= sk_data_next;
      sk_pc_reg   <= sk_pc_next;
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit. Memory word[i] = i. A scoreboard queue holds the PCs
// the IF register is expected to accept, and entries are popped on each accepted instruction.
module tb_if_fetch_unit;
  localparam int ADDR_W = 9;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] exp_q [$];

  if_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample outputs mid-cycle and retire accepted instructions against the scoreboard.
  task automatic settle();
    logic [31:0] pc;
    @(negedge clk);
    if (bus.instr_valid === 1'b1 && bus.stall === 1'b0) begin
      $display("tb: accept pc=%h instr=%h", bus.instr_pc, bus.instr);
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected: observed pc %0h expected none", bus.instr_pc);
      end
      if (exp_q.size() != 0) begin
        pc = exp_q.pop_front();
        chk("sb_pc", bus.instr_pc, pc);
        chk("sb_instr", bus.instr, pc >> 2);
      end
    end else if (bus.instr_valid !== 1'b1) begin
      chk("bubble_instr_zero", bus.instr, 32'h0);
    end
  endtask

  task automatic tick(input logic s, input logic b, input logic [31:0] t);
    @(posedge clk);
    #1;
    bus.stall         = s;
    bus.branch_taken  = b;
    bus.branch_target = t;
    settle();
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    bus.stall        = 1'b0;
    bus.branch_taken = 1'b0;
    rst              = 1'b0;
    settle();
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = i;
    rst               = 1'b0;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'h0;
    bus.imem_rdata    = 32'h0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_imem_en", bus.imem_en, 0);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_instr", bus.instr, 0);

    // Streaming immediately after reset
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    release_rst();
    chk("first_imem_en", bus.imem_en, 1);
    chk("first_imem_addr", bus.imem_addr, 0);
    chk("first_valid_low", bus.instr_valid, 0);
    tick(0, 0, 0);
    chk("valid_rise", bus.instr_valid, 1);
    repeat (3) tick(0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    settle();
    chk("rst2_valid", bus.instr_valid, 0);
    chk("rst2_imem_en", bus.imem_en, 0);
    chk("a_drained", exp_q.size(), 0);

    // Stall while 0x8 is in flight, then a branch to 0x40
    exp_q.push_back(32'h0);  exp_q.push_back(32'h4);  exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);  exp_q.push_back(32'h10); exp_q.push_back(32'h40);
    exp_q.push_back(32'h44);
    release_rst();
    tick(0, 0, 0);
    tick(0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick(1, 0, 0);
      chk("stall_valid", bus.instr_valid, 1);
      chk("stall_instr", bus.instr, 2);
      chk("stall_pc", bus.instr_pc, 32'h8);
      chk("stall_imem_en", bus.imem_en, 0);
    end
    tick(0, 0, 0);
    chk("release_imem_en", bus.imem_en, 0);
    tick(0, 0, 0);
    chk("bubble_valid", bus.instr_valid, 0);
    chk("bubble_imem_addr", bus.imem_addr, 3);
    tick(0, 0, 0);
    tick(0, 0, 0);
    tick(0, 1, 32'h40);
    chk("br_valid", bus.instr_valid, 0);
    chk("br_imem_en", bus.imem_en, 1);
    chk("br_imem_addr", bus.imem_addr, 32'h10);
    tick(0, 0, 0);
    chk("br_target_valid", bus.instr_valid, 1);
    tick(0, 0, 0);

    // Branch together with stall while the skid is full
    exp_q.push_back(32'h40); exp_q.push_back(32'h44);
    tick(1, 0, 0);
    tick(1, 0, 0);
    chk("skid_pc", bus.instr_pc, 32'h48);
    tick(1, 1, 32'h40);
    chk("brst_valid", bus.instr_valid, 0);
    chk("brst_imem_en", bus.imem_en, 1);
    chk("brst_imem_addr", bus.imem_addr, 32'h10);
    tick(1, 0, 0);
    chk("brst_tgt_pc", bus.instr_pc, 32'h40);
    chk("brst_tgt_en", bus.imem_en, 0);
    tick(1, 0, 0);
    chk("brst_skid_valid", bus.instr_valid, 1);
    chk("brst_skid_instr", bus.instr, 32'h10);
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk("brst_bubble", bus.instr_valid, 0);
    tick(0, 0, 0);

    // Unaligned target, then back-to-back branches
    exp_q.push_back(32'h80); exp_q.push_back(32'h200);
    tick(0, 1, 32'h83);
    chk("unaligned_addr", bus.imem_addr, 32'h20);
    tick(0, 0, 0);
    tick(0, 1, 32'h100);
    tick(0, 1, 32'h200);
    chk("b2b_valid", bus.instr_valid, 0);
    chk("b2b_addr", bus.imem_addr, 32'h80);
    tick(0, 0, 0);
    chk("b2b_delivered", bus.instr_valid, 1);

    // Asynchronous reset mid-stall with the skid full
    tick(1, 0, 0);
    tick(1, 0, 0);
    chk("pre_rst_pc", bus.instr_pc, 32'h204);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", bus.instr_valid, 0);
    chk("async_rst_instr", bus.instr, 0);
    chk("async_rst_en", bus.imem_en, 0);
    chk("f_drained", exp_q.size(), 0);
    bus.stall = 1'b0;
    repeat (2) @(posedge clk);
    exp_q.push_back(32'h0);
    release_rst();
    chk("restart_addr", bus.imem_addr, 0);
    tick(0, 0, 0);
    chk("restart_pc", bus.instr_pc, 32'h0);
    chk("final_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
